// File: rtl/tone_pkg.sv
// tone_pkg: constants and state encoding shared by the tone generator and the tone period decoder.
package tone_pkg;
    localparam int CNT_W = 17;
    localparam int SYNC_STAGES = 2;
    localparam logic [CNT_W-1:0] MIN_HALF = 17'd25000;
    localparam logic [CNT_W-1:0] STEP = 17'd392;
    localparam logic [CNT_W-1:0] TIMEOUT = MIN_HALF + 17'd256 * STEP;
    typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;
endpackage

// File: rtl/tone_serial_divider.sv
// tone_serial_divider: repeated-subtraction divider turning an excess half-period into a freq code.
module tone_serial_divider
    import tone_pkg::*;
#(
    parameter logic [CNT_W-1:0] STEP = tone_pkg::STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] rem_in,
    output logic [7:0]       q_out,
    output logic             done,
    output logic             busy
);
    state_t state, state_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic [7:0] q, q_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rem <= '0;
            q <= '0;
        end else begin
            state <= state_nx;
            rem <= rem_nx;
            q <= q_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx = rem;
        q_nx = q;
        case (state)
            IDLE: if (start) begin
                state_nx = DIV;
                rem_nx = rem_in;
                q_nx = '0;
            end
            DIV: if (rem >= STEP) begin
                rem_nx = rem - STEP;
                q_nx = q + 8'd1;
            end else begin
                state_nx = OUT;
            end
            OUT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_comb begin
        q_out = q;
        done = state == OUT;
        busy = state != IDLE;
    end
endmodule

// File: rtl/tone_period_decoder.sv
// tone_period_decoder: measures the half-period of snd_in and converts it back to the sequencer freq code.
module tone_period_decoder
    import tone_pkg::*;
#(
    parameter logic [CNT_W-1:0] MIN_HALF    = tone_pkg::MIN_HALF,
    parameter logic [CNT_W-1:0] STEP        = tone_pkg::STEP,
    parameter int               SYNC_STAGES = tone_pkg::SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       snd_in,
    output logic [7:0] freq_out,
    output logic       freq_valid,
    output logic       tone_present,
    output logic       out_of_range,
    output logic       busy
);
    localparam logic [CNT_W-1:0] TIMEOUT = MIN_HALF + CNT_W'(256) * STEP;

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic [7:0] q;
    logic snd_prev, armed, edge_det, timeout, accept, start, short_iv, div_done, div_busy;

    always_comb begin
        edge_det = sync[SYNC_STAGES-1] ^ snd_prev;
        timeout = cnt == TIMEOUT;
        accept = edge_det && armed && enable;
        start = accept && cnt >= MIN_HALF && !timeout && !div_busy;
        short_iv = accept && cnt < MIN_HALF;
        busy = div_busy;
    end

    // The edge cycle is the first cycle of the new interval, so cnt equals the edge spacing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            snd_prev <= 1'b0;
            cnt <= '0;
            armed <= 1'b0;
            freq_out <= '0;
            freq_valid <= 1'b0;
            tone_present <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            sync <= SYNC_STAGES'({sync, snd_in});
            snd_prev <= sync[SYNC_STAGES-1];
            cnt <= !enable ? '0 : edge_det ? CNT_W'(1) : timeout ? cnt : cnt + CNT_W'(1);
            armed <= enable && (edge_det || (armed && !timeout));
            out_of_range <= short_iv;
            freq_valid <= div_done && enable;
            if (div_done && enable) freq_out <= q;
            tone_present <= enable && !timeout && (tone_present || div_done);
        end
    end

    tone_serial_divider #(.STEP(STEP)) u_div (
        .clk   (clk),
        .rst   (rst),
        .clear (!enable),
        .start (start),
        .rem_in(cnt - MIN_HALF),
        .q_out (q),
        .done  (div_done),
        .busy  (div_busy)
    );
endmodule

// File: tb/tb_tone_period_decoder.sv
// tb_tone_period_decoder: directed edge-spacing stimulus with a scoreboard of expected freq codes and pulse times.
module tb_tone_period_decoder;
    logic clk = 0, rst = 0, enable = 0, snd_in = 0;
    logic [7:0] freq_out;
    logic freq_valid, tone_present, out_of_range, busy;
    int n_checks = 0, n_fail = 0, cyc = 0, last_t = 0, oor_exp = 0, oor_seen = 0;
    typedef struct {int f; int due;} exp_t;
    exp_t q_exp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scaled mapping: half-period = 300 + 3*freq, timeout at 1068.
    tone_period_decoder #(.MIN_HALF(17'd300), .STEP(17'd3), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .snd_in(snd_in), .freq_out(freq_out),
        .freq_valid(freq_valid), .tone_present(tone_present), .out_of_range(out_of_range), .busy(busy)
    );

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_to(int n);
        while (cyc < last_t + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle_gap(int n);
        wait_to(n);
        snd_in = ~snd_in;
        last_t = cyc;
    endtask

    // Edge detected 2 cycles after the toggle; freq_valid follows q+3 cycles later.
    task automatic edge_exp(int n, int f);
        toggle_gap(n);
        q_exp.push_back('{f, last_t + f + 5});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (out_of_range) oor_seen++;
            if (freq_valid) begin
                if (q_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got pulse with freq %0d at cycle %0d, required no pulse", freq_out, cyc);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    check("freq_out", freq_out, e.f);
                    check("valid_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_freq_out", freq_out, 0);
        check("rst_freq_valid", freq_valid, 0);
        check("rst_tone_present", tone_present, 0);
        check("rst_out_of_range", out_of_range, 0);
        check("rst_busy", busy, 0);
        rst = 1;
        enable = 1;
        last_t = cyc;
        toggle_gap(5);
        edge_exp(300, 0);
        wait_to(10);
        check("tone_present_first", tone_present, 1);
        edge_exp(300, 0);
        edge_exp(300, 0);
        edge_exp(489, 63);
        edge_exp(1067, 255);
        edge_exp(1065, 255);
        toggle_gap(1068);
        wait_to(6);
        check("timeout_exact_tp", tone_present, 0);
        toggle_gap(1200);
        wait_to(6);
        check("timeout_long_tp", tone_present, 0);
        edge_exp(414, 38);
        toggle_gap(100);
        oor_exp++;
        wait_to(10);
        check("glitch_freq_hold", freq_out, 38);
        check("glitch_oor_count", oor_seen, 1);
        edge_exp(414, 38);
        toggle_gap(489);
        wait_to(10);
        check("div_busy", busy, 1);
        enable = 0;
        wait_to(11);
        check("disable_busy", busy, 0);
        check("disable_tp", tone_present, 0);
        wait_to(31);
        enable = 1;
        toggle_gap(40);
        edge_exp(351, 17);
        toggle_gap(489);
        wait_to(20);
        #2;
        rst = 0;
        #1;
        check("async_rst_freq_out", freq_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_tp", tone_present, 0);
        check("async_rst_valid", freq_valid, 0);
        snd_in = 0;
        wait_to(25);
        rst = 1;
        last_t = cyc;
        toggle_gap(50);
        edge_exp(300, 0);
        wait_to(20);
        check("queue_empty", q_exp.size(), 0);
        check("oor_total", oor_seen, oor_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
